wb_unit: RTL

//  Parametrised writeback stage for the rv32i pipeline; replaces the fixed combinational writeback.

---
 rtl/wb_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wb_unit.sv
// Writeback stage: retires one instruction per handshake. Load data is aligned and
// extended here, and late load responses are waited for, up to LOAD_TIMEOUT cycles.
module wb_unit #(
  parameter  int XLEN         = 32,
  parameter  int NREGS        = 32,
  parameter  int LOAD_TIMEOUT = 16,
  parameter  int CNT_W        = 64,
  localparam int AW           = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             reg_write_i,
  input  logic             is_load_i,
  input  logic [2:0]       funct3_i,
  input  logic [2:0]       addr_lsb_i,
  input  logic [AW-1:0]    rd_i,
  input  logic [XLEN-1:0]  result_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic             reg_write_o,
  output logic [AW-1:0]    reg_waddr_o,
  output logic [XLEN-1:0]  reg_wdata_o,
  output logic             err_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int TW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [AW-1:0]   pend_rd;
  logic [2:0]      pend_f3;
  logic [2:0]      pend_lsb;
  logic            pend_wen;

  logic            accept;
  logic            in_legal;
  logic            retire;
  logic            wr_en_nxt;
  logic [AW-1:0]   wr_addr_nxt;
  logic [XLEN-1:0] wr_data_nxt;
  logic            err_nxt;
  logic            go_wait;
  logic            timed_out;

  // Byte offset within the memory word; bit 2 only matters for doubleword memory.
  function automatic logic [2:0] load_off(input logic [2:0] lsb);
    return (XLEN == 64) ? lsb : {1'b0, lsb[1:0]};
  endfunction

  function automatic logic load_legal(input logic [2:0] f3, input logic [2:0] lsb);
    logic [2:0] off;
    off = load_off(lsb);
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return !off[0];
      3'b010:         return off[1:0] == 2'b00;
      3'b110:         return (XLEN == 64) && (off[1:0] == 2'b00);
      3'b011:         return (XLEN == 64) && (off == 3'b000);
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_align(input logic [2:0] f3, input logic [2:0] lsb,
                                                 input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] w32;
    shifted = rdata >> {load_off(lsb), 3'b000};
    b8  = shifted[7:0];
    h16 = shifted[15:0];
    w32 = shifted[31:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? XLEN'(shifted[7:0])  : XLEN'(b8);
      2'b01:   return f3[2] ? XLEN'(shifted[15:0]) : XLEN'(h16);
      2'b10:   return f3[2] ? XLEN'(shifted[31:0]) : XLEN'(w32);
      default: return shifted;
    endcase
  endfunction

  assign accept    = valid_i && (state == IDLE);
  assign in_legal  = load_legal(funct3_i, addr_lsb_i);
  assign go_wait   = accept && is_load_i && in_legal && !mem_rvalid_i;
  assign timed_out = (state == WAIT_LOAD) && !mem_rvalid_i && (timer == TW'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (go_wait) state_nxt = WAIT_LOAD;
      WAIT_LOAD: if (mem_rvalid_i || timed_out) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o     = (state == IDLE);
    retire      = 1'b0;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = rd_i;
    wr_data_nxt = result_i;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_load_i) begin
            retire    = 1'b1;
            wr_en_nxt = reg_write_i && (rd_i != '0);
          end else if (!in_legal) begin
            err_nxt = 1'b1;
          end else if (mem_rvalid_i) begin
            retire      = 1'b1;
            wr_en_nxt   = reg_write_i && (rd_i != '0);
            wr_data_nxt = load_align(funct3_i, addr_lsb_i, mem_rdata_i);
          end
        end
      end
      WAIT_LOAD: begin
        wr_addr_nxt = pend_rd;
        wr_data_nxt = load_align(pend_f3, pend_lsb, mem_rdata_i);
        if (mem_rvalid_i) begin
          retire    = 1'b1;
          wr_en_nxt = pend_wen && (pend_rd != '0);
        end else if (timed_out) begin
          err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer       <= '0;
      pend_rd     <= '0;
      pend_f3     <= '0;
      pend_lsb    <= '0;
      pend_wen    <= 1'b0;
      reg_write_o <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      err_o       <= 1'b0;
      instret_o   <= '0;
    end else begin
      if (go_wait) begin
        timer    <= '0;
        pend_rd  <= rd_i;
        pend_f3  <= funct3_i;
        pend_lsb <= addr_lsb_i;
        pend_wen <= reg_write_i;
      end else if (state == WAIT_LOAD && !mem_rvalid_i) begin
        timer <= timer + 1'b1;
      end
      reg_write_o <= wr_en_nxt;
      if (wr_en_nxt) begin
        reg_waddr_o <= wr_addr_nxt;
        reg_wdata_o <= wr_data_nxt;
      end
      err_o <= err_nxt;
      if (retire) instret_o <= instret_o + 1'b1;
    end
  end

endmodule
